// File: rtl/i2c_target.sv
// I2C target (slave) with oversampled SCL/SDA: answers SLAVE_ADDR, accepts write
// bytes on a rx_valid/rx_ready handshake and returns tx_data bytes on reads.
module i2c_target #(
   parameter logic [6:0] SLAVE_ADDR = 7'h69
) (
   input  logic       i2c_clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy,
   output logic [2:0] state_out
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      WRITE     = 3'd3,
      WRITE_ACK = 3'd4,
      READ      = 3'd5,
      READ_ACK  = 3'd6,
      WAIT_STOP = 3'd7
   } state_t;

   logic       scl_s1_q, scl_s2_q, scl_prev_q;
   logic       sda_s1_q, sda_s2_q, sda_prev_q;
   logic [1:0] settle_q, settle_d;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [6:0] tx_sh_q, tx_sh_d;
   logic       rw_q, rw_d;
   logic [1:0] phase_q, phase_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q, tx_req_d;

   logic       events_ok;
   logic       scl_rise, scl_fall, scl_high;
   logic       start_det, stop_det;
   logic [7:0] shift_in;

   // Synchronizers idle high so a reset looks like a quiet bus.
   always_ff @(posedge i2c_clk or negedge reset) begin
      if (!reset) begin
         scl_s1_q   <= 1'b1;
         scl_s2_q   <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_s1_q   <= 1'b1;
         sda_s2_q   <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_s1_q   <= scl;
         scl_s2_q   <= scl_s1_q;
         scl_prev_q <= scl_s2_q;
         sda_s1_q   <= sda_in;
         sda_s2_q   <= sda_s1_q;
         sda_prev_q <= sda_s2_q;
      end
   end

   // Edges are masked until the pipeline has flushed its reset value, so a
   // low SDA at reset release is not mistaken for a START.
   always_comb begin
      settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
   end

   assign events_ok = (settle_q == 2'd3);
   assign scl_rise  = events_ok & scl_s2_q & ~scl_prev_q;
   assign scl_fall  = events_ok & ~scl_s2_q & scl_prev_q;
   assign scl_high  = scl_s2_q & scl_prev_q;
   assign start_det = events_ok & scl_high & ~sda_s2_q & sda_prev_q;
   assign stop_det  = events_ok & scl_high & sda_s2_q & ~sda_prev_q;
   assign shift_in  = {shift_q, sda_s2_q};

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_sh_d    = tx_sh_q;
      rw_d       = rw_q;
      phase_d    = phase_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;

      if (stop_det) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         phase_d  = 2'd0;
      end else if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = 3'd0;
         shift_d   = 7'd0;
         sda_oe_d  = 1'b0;
         phase_d   = 2'd0;
      end else begin
         case (state_q)
            ADDR: begin
               if (scl_rise) begin
                  shift_d   = shift_in[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rw_d    = sda_s2_q;
                     phase_d = 2'd0;
                     state_d = (shift_q == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                  end
               end
            end

            // phase 0: waiting for the fall that starts the ACK slot;
            // phase 1: ACK driven, waiting for the fall that ends it.
            ADDR_ACK, WRITE_ACK: begin
               if (scl_fall) begin
                  if (phase_q == 2'd0) begin
                     sda_oe_d = 1'b1;
                     phase_d  = 2'd1;
                  end else begin
                     phase_d   = 2'd0;
                     bit_cnt_d = 3'd0;
                     shift_d   = 7'd0;
                     if (state_q == WRITE_ACK || !rw_q) begin
                        state_d  = WRITE;
                        sda_oe_d = 1'b0;
                     end else begin
                        state_d  = READ;
                        tx_sh_d  = tx_data[6:0];
                        tx_req_d = 1'b1;
                        sda_oe_d = ~tx_data[7];
                     end
                  end
               end
            end

            WRITE: begin
               if (scl_rise) begin
                  shift_d   = shift_in[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     phase_d = 2'd0;
                     if (rx_ready) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        state_d    = WRITE_ACK;
                     end else begin
                        state_d = WAIT_STOP;
                     end
                  end
               end
            end

            READ: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = READ_ACK;
                     phase_d = 2'd0;
                  end
               end else if (scl_fall) begin
                  sda_oe_d = ~tx_sh_q[6];
                  tx_sh_d  = {tx_sh_q[5:0], 1'b0};
               end
            end

            // phase 0: release after last bit; 1: sample initiator ACK;
            // 2: ACK seen, start next byte on the following fall.
            READ_ACK: begin
               case (phase_q)
                  2'd0: begin
                     if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        phase_d  = 2'd1;
                     end
                  end
                  2'd1: begin
                     if (scl_rise) begin
                        if (!sda_s2_q) begin
                           phase_d = 2'd2;
                        end else begin
                           phase_d = 2'd0;
                           state_d = WAIT_STOP;
                        end
                     end
                  end
                  default: begin
                     if (scl_fall) begin
                        phase_d   = 2'd0;
                        bit_cnt_d = 3'd0;
                        state_d   = READ;
                        tx_sh_d   = tx_data[6:0];
                        tx_req_d  = 1'b1;
                        sda_oe_d  = ~tx_data[7];
                     end
                  end
               endcase
            end

            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge i2c_clk or negedge reset) begin
      if (!reset) begin
         settle_q   <= 2'd0;
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 7'd0;
         tx_sh_q    <= 7'd0;
         rw_q       <= 1'b0;
         phase_q    <= 2'd0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
      end else begin
         settle_q   <= settle_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_sh_q    <= tx_sh_d;
         rw_q       <= rw_d;
         phase_q    <= phase_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
      end
   end

   assign sda_oe    = sda_oe_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign tx_req    = tx_req_q;
   assign busy      = (state_q != IDLE);
   assign state_out = state_q;

endmodule
